nibble_sequencer: RTL and testbench
===================================

# nibble_sequencer

Control sequencer for the 4-bit CPU, directly downstream of the fetch stage (PC counter, program ROM, 8-bit fetch register). Consumes `instr`/`oprnd` and the raw `program_byte`. Generates the fetch stage's `en_PC`, `en_Fetch`, `loact`, `load`, plus datapath strobes for accumulator/ALU/RAM/IO. Owns the C/Z flag register and resolves conditional jumps.

## Interface
Parameters:
- `ADDR_W`, 12: program/RAM address width.

Ports:
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-low; all state cleared on the clock edge where `reset==0`.
- `run` in 1: level enable; sampled only in FETCH.
- `instr` in 4: opcode from the fetch register.
- `oprnd` in 4: operand nibble from the fetch register.
- `program_byte` in 8: current ROM output (second instruction byte).
- `alu_c`, `alu_z` in 1 each: ALU carry/zero of the current operation.
- `en_PC`, `en_Fetch`, `loact` out 1 each: fetch-stage controls.
- `load` out 12: PC load value.
- `ram_addr` out 12: data RAM address.
- `acc_we`, `imm_oe`, `ram_oe`, `ram_we`, `in_oe`, `out_we` out 1 each: datapath strobes.
- `alu_sel` out 2: 00 PASS, 01 SUB (A−B), 10 ADD, 11 NAND.
- `c_flag`, `z_flag` out 1 each: registered flags.

## Operation
- Opcodes: 0 JC, 1 JNC, 2 CMPI, 3 CMPM, 4 LIT, 5 IN, 6 LD, 7 ST, 8 JZ, 9 JNZ, A ADDI, B ADDM, C JMP, D OUT, E NANDI, F NANDM.
- Two-byte ops: 0,1,3,6,7,8,9,B,C,F. The second byte is the low address; the full address is {`oprnd`, `program_byte`}. All other opcodes are one-byte.
- FETCH: if `run`, assert `en_Fetch` and `en_PC`. Next state is ADDR for a two-byte opcode, EXEC otherwise. If `run==0`, all outputs stay 0 and the block holds in FETCH. Decode uses the value latched at the FETCH edge, so ADDR/EXEC read `instr`.
- ADDR: capture {`oprnd`, `program_byte`} into `addr_reg`. Assert `en_PC` to step past the byte. Go to EXEC.
- EXEC: one cycle of strobes, then go to FETCH.
  - `ram_addr` = `addr_reg`.
  - Immediates: `imm_oe=1`.
  - Memory ops: `ram_oe=1`. ST uses `ram_we=1` instead.
  - Accumulator writers: LIT, IN, LD, ADDI/M, NANDI/M assert `acc_we=1`.
  - CMPI/M: SUB, no `acc_we`.
  - OUT: `out_we=1`. IN: `in_oe=1`.
- Jumps in EXEC: if taken, `loact=1` and `load=addr_reg`; otherwise nothing.
  - JC taken when C=1; JNC when C=0; JZ when Z=1; JNZ when Z=0; JMP always.
- Flags, updated at the EXEC edge:
  - CMP*/ADD*: C←`alu_c`, Z←`alu_z`.
  - NAND*: Z←`alu_z` only; C unchanged.
  - All other opcodes leave both flags unchanged.
- `loact` and `en_PC` are never asserted in the same cycle.

## Timing
- Reset (`reset==0` at the edge): state=FETCH, C=Z=0, `addr_reg`=0. While `reset==0`, all outputs are forced to 0 combinationally.
- Reset mid-instruction: the instruction is abandoned with no strobes in the reset cycle. Restart is in FETCH at the first edge after release.
- Control outputs are combinational from state+`instr`+flags. State, flags and `addr_reg` are registered.
- One-byte instruction: 2 cycles (FETCH, EXEC).
- Two-byte instruction: 3 cycles (FETCH, ADDR, EXEC).
- Jump target: fetched in the FETCH directly after EXEC.
- `run` deasserted mid-instruction has no effect until the block returns to FETCH.
- A flag written in EXEC is visible to a jump's EXEC at the earliest 3 cycles later.

## Configuration
- `NIBBLE_SEQ_STEP_EN` defined:
  - Adds input `step` (1 bit). `step` is registered and edge-detected on the rising edge.
  - FETCH proceeds only after a `step` rising edge with `run==1`. Exactly one instruction executes per pulse.
  - A pulse arriving outside FETCH is remembered, at most one pending.
- Not defined: `step` port absent; `run` alone gates FETCH.

## Structure
- `nibble_pkg`: opcode constants, state encodings (FETCH=0, ADDR=1, EXEC=2), `alu_sel` codes, and the two-byte opcode mask.
- Sub-module `nibble_flags`: C/Z register with synchronous active-low reset and per-flag write enables.

## Test plan
- Reset low 3 cycles with `run=1` → all outputs 0. After release, cycle 1 shows `en_PC=en_Fetch=1` and C=Z=0.
- LIT (byte 0x47) → EXEC: `acc_we=1`, `imm_oe=1`, `alu_sel=00`. Back in FETCH after 2 cycles; flags unchanged.
- ADDI with `alu_c=1`, `alu_z=1` in EXEC → C=1, Z=1 next cycle. A following NANDI with `alu_z=0` → Z=0, C stays 1.
- JC 0x3A5 (bytes 0x03, 0xA5) with C=1 → ADDR: `en_PC=1`. EXEC: `loact=1`, `load=0x3A5`. With C=0 → EXEC shows `loact=0`, and PC continues at +2.
- ST 0x812 → EXEC: `ram_addr=0x812`, `ram_we=1`, no `acc_we`. Reset low during ADDR → no EXEC strobes, and FETCH follows release.
- `NIBBLE_SEQ_STEP_EN` build: two `step` pulses → exactly two instructions, then idle in FETCH with `en_PC=0`.

Source files
------------

// File: rtl/nibble_pkg.sv
// Shared constants for the nibble CPU sequencer: opcodes, FSM state codes,
// ALU select codes and the two-byte opcode mask.
package nibble_pkg;

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_ADDR  = 2'd1;
  localparam logic [1:0] ST_EXEC  = 2'd2;

  localparam logic [3:0] OP_JC    = 4'h0;
  localparam logic [3:0] OP_JNC   = 4'h1;
  localparam logic [3:0] OP_CMPI  = 4'h2;
  localparam logic [3:0] OP_CMPM  = 4'h3;
  localparam logic [3:0] OP_LIT   = 4'h4;
  localparam logic [3:0] OP_IN    = 4'h5;
  localparam logic [3:0] OP_LD    = 4'h6;
  localparam logic [3:0] OP_ST    = 4'h7;
  localparam logic [3:0] OP_JZ    = 4'h8;
  localparam logic [3:0] OP_JNZ   = 4'h9;
  localparam logic [3:0] OP_ADDI  = 4'hA;
  localparam logic [3:0] OP_ADDM  = 4'hB;
  localparam logic [3:0] OP_JMP   = 4'hC;
  localparam logic [3:0] OP_OUT   = 4'hD;
  localparam logic [3:0] OP_NANDI = 4'hE;
  localparam logic [3:0] OP_NANDM = 4'hF;

  localparam logic [1:0] ALU_PASS = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_ADD  = 2'b10;
  localparam logic [1:0] ALU_NAND = 2'b11;

  // Bit n set means opcode n carries a second (low address) byte:
  // 0,1,3,6,7,8,9,B,C,F.
  localparam logic [15:0] TWO_BYTE_MASK = 16'b1001_1011_1100_1011;

  function automatic logic is_two_byte(input logic [3:0] op);
    return TWO_BYTE_MASK[op];
  endfunction

endpackage

// File: rtl/nibble_flags.sv
// C/Z flag register with independent write enables.
module nibble_flags (
  input  logic clk,
  input  logic reset,
  input  logic c_we,
  input  logic z_we,
  input  logic c_in,
  input  logic z_in,
  output logic c,
  output logic z
);

  // Each flag only moves when its own enable is set.
  always_ff @(posedge clk) begin
    if (!reset) begin
      c <= 1'b0;
      z <= 1'b0;
    end else begin
      if (c_we) c <= c_in;
      if (z_we) z <= z_in;
    end
  end

endmodule

// File: rtl/nibble_sequencer.sv
// Control sequencer for the 4-bit CPU: FETCH -> [ADDR] -> EXEC.
// Optional single-step gating is enabled by defining NIBBLE_SEQ_STEP_EN.
module nibble_sequencer
  import nibble_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
`ifdef NIBBLE_SEQ_STEP_EN
  input  logic              step,
`endif
  input  logic [3:0]        instr,
  input  logic [3:0]        oprnd,
  input  logic [7:0]        program_byte,
  input  logic              alu_c,
  input  logic              alu_z,
  output logic              en_PC,
  output logic              en_Fetch,
  output logic              loact,
  output logic [ADDR_W-1:0] load,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              acc_we,
  output logic              imm_oe,
  output logic              ram_oe,
  output logic              ram_we,
  output logic              in_oe,
  output logic              out_we,
  output logic [1:0]        alu_sel,
  output logic              c_flag,
  output logic              z_flag
);

  logic [1:0]        state, state_nxt;
  logic [ADDR_W-1:0] addr_reg;
  logic              go;
  logic              c_q, z_q, c_we, z_we;

`ifdef NIBBLE_SEQ_STEP_EN
  logic step_q, step_qq, step_pend, rise;
  assign rise = step_q & ~step_qq;
  assign go   = run & (step_pend | rise);

  // Register step, detect its rising edge, and hold one pulse until FETCH uses it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      step_q    <= 1'b0;
      step_qq   <= 1'b0;
      step_pend <= 1'b0;
    end else begin
      step_q  <= step;
      step_qq <= step_q;
      if (state == ST_FETCH && go) step_pend <= step_pend & rise;
      else if (rise)               step_pend <= 1'b1;
    end
  end
`else
  assign go = run;
`endif

  // Next-state and strobe decode; reset low forces every output to zero.
  always_comb begin
    state_nxt = state;
    en_PC     = 1'b0;
    en_Fetch  = 1'b0;
    loact     = 1'b0;
    load      = '0;
    ram_addr  = '0;
    acc_we    = 1'b0;
    imm_oe    = 1'b0;
    ram_oe    = 1'b0;
    ram_we    = 1'b0;
    in_oe     = 1'b0;
    out_we    = 1'b0;
    alu_sel   = ALU_PASS;
    c_we      = 1'b0;
    z_we      = 1'b0;
    case (state)
      ST_FETCH: begin
        // The fetch register is loaded at this edge, so decode the ROM byte.
        if (go) begin
          en_Fetch  = 1'b1;
          en_PC     = 1'b1;
          state_nxt = is_two_byte(program_byte[7:4]) ? ST_ADDR : ST_EXEC;
        end
      end
      ST_ADDR: begin
        en_PC     = 1'b1;
        state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        state_nxt = ST_FETCH;
        ram_addr  = addr_reg;
        case (instr)
          OP_JC:    loact = c_q;
          OP_JNC:   loact = ~c_q;
          OP_JZ:    loact = z_q;
          OP_JNZ:   loact = ~z_q;
          OP_JMP:   loact = 1'b1;
          OP_CMPI:  begin imm_oe = 1'b1; alu_sel = ALU_SUB; c_we = 1'b1; z_we = 1'b1; end
          OP_CMPM:  begin ram_oe = 1'b1; alu_sel = ALU_SUB; c_we = 1'b1; z_we = 1'b1; end
          OP_LIT:   begin imm_oe = 1'b1; acc_we = 1'b1; end
          OP_IN:    begin in_oe  = 1'b1; acc_we = 1'b1; end
          OP_LD:    begin ram_oe = 1'b1; acc_we = 1'b1; end
          OP_ST:    ram_we = 1'b1;
          OP_ADDI:  begin imm_oe = 1'b1; acc_we = 1'b1; alu_sel = ALU_ADD; c_we = 1'b1; z_we = 1'b1; end
          OP_ADDM:  begin ram_oe = 1'b1; acc_we = 1'b1; alu_sel = ALU_ADD; c_we = 1'b1; z_we = 1'b1; end
          OP_OUT:   out_we = 1'b1;
          OP_NANDI: begin imm_oe = 1'b1; acc_we = 1'b1; alu_sel = ALU_NAND; z_we = 1'b1; end
          OP_NANDM: begin ram_oe = 1'b1; acc_we = 1'b1; alu_sel = ALU_NAND; z_we = 1'b1; end
          default:  ;
        endcase
        if (loact) load = addr_reg;
      end
      default: state_nxt = ST_FETCH;
    endcase
    if (!reset) begin
      en_PC    = 1'b0;
      en_Fetch = 1'b0;
      loact    = 1'b0;
      load     = '0;
      ram_addr = '0;
      acc_we   = 1'b0;
      imm_oe   = 1'b0;
      ram_oe   = 1'b0;
      ram_we   = 1'b0;
      in_oe    = 1'b0;
      out_we   = 1'b0;
      alu_sel  = ALU_PASS;
    end
  end

  // State register and second-byte address capture.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ST_FETCH;
      addr_reg <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_ADDR) addr_reg <= ADDR_W'({oprnd, program_byte});
    end
  end

  nibble_flags u_flags (
    .clk   (clk),
    .reset (reset),
    .c_we  (c_we),
    .z_we  (z_we),
    .c_in  (alu_c),
    .z_in  (alu_z),
    .c     (c_q),
    .z     (z_q)
  );

  assign c_flag = reset & c_q;
  assign z_flag = reset & z_q;

endmodule

// File: tb/tb_nibble_sequencer.sv
// Self-checking bench for nibble_sequencer. The bench plays the fetch stage:
// each cycle it drives the fetch register / ROM byte and pushes the expected
// control vector to a scoreboard, which is popped and compared at negedge.
module tb_nibble_sequencer;

  typedef struct packed {
    logic        en_pc, en_fetch, loact;
    logic [11:0] load, ram_addr;
    logic        acc_we, imm_oe, ram_oe, ram_we, in_oe, out_we;
    logic [1:0]  alu_sel;
    logic        c, z;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, run, alu_c, alu_z;
  logic [3:0]  instr, oprnd;
  logic [7:0]  program_byte;
  logic        en_PC, en_Fetch, loact, acc_we, imm_oe, ram_oe, ram_we, in_oe, out_we;
  logic        c_flag, z_flag;
  logic [11:0] load, ram_addr;
  logic [1:0]  alu_sel;
`ifdef NIBBLE_SEQ_STEP_EN
  logic        step;
`endif

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];
  logic c_m, z_m;
  logic [11:0] areg;

  always #5 clk = ~clk;

  nibble_sequencer #(.ADDR_W(12)) dut (
    .clk(clk), .reset(reset), .run(run),
`ifdef NIBBLE_SEQ_STEP_EN
    .step(step),
`endif
    .instr(instr), .oprnd(oprnd), .program_byte(program_byte),
    .alu_c(alu_c), .alu_z(alu_z),
    .en_PC(en_PC), .en_Fetch(en_Fetch), .loact(loact), .load(load),
    .ram_addr(ram_addr), .acc_we(acc_we), .imm_oe(imm_oe), .ram_oe(ram_oe),
    .ram_we(ram_we), .in_oe(in_oe), .out_we(out_we), .alu_sel(alu_sel),
    .c_flag(c_flag), .z_flag(z_flag)
  );

  function automatic exp_t idle_e();
    exp_t e = '0;
    e.c = c_m;
    e.z = z_m;
    return e;
  endfunction

  function automatic exp_t fetch_e();
    exp_t e = idle_e();
    e.en_pc = 1'b1;
    e.en_fetch = 1'b1;
    return e;
  endfunction

  function automatic exp_t addr_e();
    exp_t e = idle_e();
    e.en_pc = 1'b1;
    return e;
  endfunction

  function automatic exp_t exec_e();
    exp_t e = idle_e();
    e.ram_addr = areg;
    return e;
  endfunction

  // One clock: drive inputs, queue expectation, compare at negedge, step to next edge.
  task automatic cyc(input string nm, input logic r, input logic rst, input logic [7:0] fr,
                     input logic [7:0] pb, input logic ac, input logic az, input exp_t e);
    exp_t got, want;
    run = r; reset = rst; {instr, oprnd} = fr; program_byte = pb; alu_c = ac; alu_z = az;
    sb.push_back(e);
    @(negedge clk);
    got = {en_PC, en_Fetch, loact, load, ram_addr, acc_we, imm_oe, ram_oe, ram_we,
           in_oe, out_we, alu_sel, c_flag, z_flag};
    want = sb.pop_front();
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", nm, got, want);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_hold();
    for (int i = 0; i < 3; i++) cyc("reset_hold", 1, 0, 8'h00, 8'h47, 1, 1, '0);
    c_m = 0; z_m = 0; areg = '0;
  endtask

  task automatic test_reset_release();
    exp_t e;
    cyc("reset_release", 1, 1, 8'h00, 8'h40, 0, 0, fetch_e());
    e = exec_e(); e.acc_we = 1; e.imm_oe = 1;
    cyc("reset_first_exec", 1, 1, 8'h40, 8'h00, 0, 0, e);
  endtask

  task automatic test_lit();
    exp_t e;
    cyc("lit_fetch", 1, 1, 8'h40, 8'h47, 1, 1, fetch_e());
    e = exec_e(); e.acc_we = 1; e.imm_oe = 1; e.alu_sel = 2'b00;
    cyc("lit_exec", 1, 1, 8'h47, 8'h00, 1, 1, e);
  endtask

  task automatic test_flags();
    exp_t e;
    cyc("addi_fetch", 1, 1, 8'h47, 8'hA3, 0, 0, fetch_e());
    e = exec_e(); e.acc_we = 1; e.imm_oe = 1; e.alu_sel = 2'b10;
    cyc("addi_exec", 1, 1, 8'hA3, 8'h00, 1, 1, e);
    c_m = 1; z_m = 1;
    cyc("nandi_fetch", 1, 1, 8'hA3, 8'hE5, 0, 0, fetch_e());
    e = exec_e(); e.acc_we = 1; e.imm_oe = 1; e.alu_sel = 2'b11;
    cyc("nandi_exec", 1, 1, 8'hE5, 8'h00, 0, 0, e);
    z_m = 0;
  endtask

  // Two-byte jump: FETCH, ADDR, EXEC with taken/not-taken expectation.
  task automatic jump(input string nm, input logic [7:0] b0, input logic [7:0] b1, input logic taken);
    exp_t e;
    cyc({nm, "_fetch"}, 1, 1, 8'h00, b0, 0, 0, fetch_e());
    cyc({nm, "_addr"}, 1, 1, b0, b1, 0, 0, addr_e());
    areg = {b0[3:0], b1};
    e = exec_e();
    if (taken) begin e.loact = 1; e.load = areg; end
    cyc({nm, "_exec"}, 1, 1, b0, 8'h00, 0, 0, e);
  endtask

  task automatic test_jumps();
    exp_t e;
    jump("jc_taken", 8'h03, 8'hA5, 1);
    cyc("cmpi_fetch", 1, 1, 8'h03, 8'h27, 0, 0, fetch_e());
    e = exec_e(); e.imm_oe = 1; e.alu_sel = 2'b01;
    cyc("cmpi_exec", 1, 1, 8'h27, 8'h00, 0, 0, e);
    c_m = 0; z_m = 0;
    jump("jc_not_taken", 8'h03, 8'hA5, 0);
    jump("jnz_taken", 8'h91, 8'h23, 1);
    jump("jz_not_taken", 8'h84, 8'h56, 0);
    jump("jmp", 8'hC7, 8'h89, 1);
    jump("jnc_taken", 8'h1F, 8'hFF, 1);
  endtask

  // Two-byte memory op; the bench names the strobes and resulting flags.
  task automatic memop(input string nm, input logic [7:0] b0, input logic [7:0] b1, input logic ac,
                       input logic az, input exp_t strobes, input logic nc, input logic nz);
    exp_t e;
    cyc({nm, "_fetch"}, 1, 1, 8'h00, b0, 0, 0, fetch_e());
    cyc({nm, "_addr"}, 1, 1, b0, b1, 0, 0, addr_e());
    areg = {b0[3:0], b1};
    e = exec_e() | strobes;
    cyc({nm, "_exec"}, 1, 1, b0, 8'h00, ac, az, e);
    c_m = nc; z_m = nz;
  endtask

  task automatic test_mem();
    exp_t s;
    s = '0; s.ram_we = 1;
    memop("st", 8'h78, 8'h12, 1, 1, s, c_m, z_m);
    s = '0; s.ram_oe = 1; s.acc_we = 1;
    memop("ld", 8'h6A, 8'h34, 1, 1, s, c_m, z_m);
    s = '0; s.ram_oe = 1; s.alu_sel = 2'b01;
    memop("cmpm", 8'h3B, 8'hCD, 1, 0, s, 1, 0);
    s = '0; s.ram_oe = 1; s.acc_we = 1; s.alu_sel = 2'b10;
    memop("addm", 8'hB0, 8'h01, 0, 1, s, 0, 1);
    s = '0; s.ram_oe = 1; s.acc_we = 1; s.alu_sel = 2'b11;
    memop("nandm", 8'hF0, 8'h02, 1, 0, s, 0, 0);
  endtask

  task automatic test_io();
    exp_t e;
    cyc("out_fetch", 1, 1, 8'h00, 8'hD0, 0, 0, fetch_e());
    e = exec_e(); e.out_we = 1;
    cyc("out_exec", 1, 1, 8'hD0, 8'h00, 1, 1, e);
    cyc("in_fetch", 1, 1, 8'hD0, 8'h50, 0, 0, fetch_e());
    e = exec_e(); e.in_oe = 1; e.acc_we = 1;
    cyc("in_exec", 1, 1, 8'h50, 8'h00, 1, 1, e);
  endtask

  task automatic test_run();
    exp_t e;
    cyc("run_low_hold", 0, 1, 8'h00, 8'h61, 0, 0, idle_e());
    cyc("run_low_hold", 0, 1, 8'h00, 8'h61, 0, 0, idle_e());
    cyc("run_drop_fetch", 1, 1, 8'h00, 8'h61, 0, 0, fetch_e());
    cyc("run_drop_addr", 0, 1, 8'h61, 8'h11, 0, 0, addr_e());
    areg = 12'h111;
    e = exec_e(); e.ram_oe = 1; e.acc_we = 1;
    cyc("run_drop_exec", 0, 1, 8'h61, 8'h00, 0, 0, e);
    cyc("run_drop_idle", 0, 1, 8'h61, 8'h40, 0, 0, idle_e());
  endtask

  task automatic test_reset_mid();
    exp_t e;
    cyc("rmid_fetch", 1, 1, 8'h00, 8'h7A, 0, 0, fetch_e());
    cyc("rmid_addr_reset", 1, 0, 8'h7A, 8'hBC, 0, 0, '0);
    c_m = 0; z_m = 0; areg = '0;
    cyc("rmid_release_fetch", 1, 1, 8'h7A, 8'hD0, 0, 0, fetch_e());
    e = exec_e(); e.out_we = 1;
    cyc("rmid_out_exec", 1, 1, 8'hD0, 8'h00, 0, 0, e);
  endtask

  task automatic test_back_to_back();
    exp_t e;
    cyc("b2b_addi_fetch", 1, 1, 8'h00, 8'hA1, 0, 0, fetch_e());
    e = exec_e(); e.imm_oe = 1; e.acc_we = 1; e.alu_sel = 2'b10;
    cyc("b2b_addi_exec", 1, 1, 8'hA1, 8'h00, 1, 0, e);
    c_m = 1; z_m = 0;
    jump("b2b_jc", 8'h00, 8'h10, 1);
  endtask

`ifdef NIBBLE_SEQ_STEP_EN
  task automatic test_step();
    exp_t e;
    step = 0;
    cyc("step_idle", 1, 1, 8'h00, 8'h47, 0, 0, idle_e());
    cyc("step_idle", 1, 1, 8'h00, 8'h47, 0, 0, idle_e());
    for (int p = 0; p < 2; p++) begin
      step = 1;
      cyc("step_wait", 1, 1, 8'h00, 8'h47, 0, 0, idle_e());
      step = 0;
      cyc("step_fetch", 1, 1, 8'h00, 8'h47, 0, 0, fetch_e());
      e = exec_e(); e.acc_we = 1; e.imm_oe = 1;
      cyc("step_exec", 1, 1, 8'h47, 8'h47, 0, 0, e);
    end
    cyc("step_done", 1, 1, 8'h47, 8'h47, 0, 0, idle_e());
    cyc("step_done", 1, 1, 8'h47, 8'h47, 0, 0, idle_e());
  endtask
`endif

  initial begin
    reset = 0; run = 1; instr = 0; oprnd = 0; program_byte = 0; alu_c = 0; alu_z = 0;
    c_m = 0; z_m = 0; areg = '0;
`ifdef NIBBLE_SEQ_STEP_EN
    step = 0;
`endif
    @(posedge clk); #1;
    test_reset_hold();
`ifdef NIBBLE_SEQ_STEP_EN
    test_step();
`else
    test_reset_release();
    test_lit();
    test_flags();
    test_jumps();
    test_mem();
    test_io();
    test_run();
    test_reset_mid();
    test_back_to_back();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
